// File: rtl/uart_host_sequencer.sv
// Host-side sequencer for a simple UART core: turns host write/read/clear requests into
// single-cycle ren/wen strobes on control[3:2], with settle and idle-gap cycles in between.
module uart_host_sequencer #(
   parameter int unsigned GapCycles = 1
) (
   input  logic       clk,
   input  logic       nReset,
   input  logic       tx_valid,
   input  logic [7:0] tx_byte,
   output logic       tx_ready,
   input  logic       rx_req,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   input  logic       rx_ready,
   input  logic       clear_req,
   input  logic [1:0] rate_sel,
   output logic [3:0] control,
   output logic [7:0] tx_data,
   input  logic [7:0] rx_data,
   output logic       busy
);

   typedef enum logic [2:0] {
      StIdle, StWrStb, StWrHold, StRdStb, StRdCap, StClrStb, StRel, StGap
   } stateE;

   localparam bit       NoGap   = (GapCycles == 0);
   localparam logic [3:0] GapLoad = 4'(GapCycles - 1);

   stateE       stateQ, stateD;
   logic [3:0]  gapCntQ, gapCntD;
   logic [7:0]  txDataQ, rxByteQ;
   logic        rxValidQ, rxValidD;
   logic [1:0]  rateQ;
   logic        startedQ;
   logic [1:0]  strobe;
   logic        idleArb, canRead, winClr, winRd, winWr;

   // No arbitration in the first cycle after reset release, so the first strobe
   // can only follow the second clock edge.
   assign idleArb = (stateQ == StIdle) && startedQ;
   assign canRead = !rxValidQ || rx_ready;
   assign winClr  = idleArb && clear_req;
   assign winRd   = idleArb && !clear_req && rx_req && canRead;
   assign winWr   = idleArb && !clear_req && !(rx_req && canRead) && tx_valid;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         stateQ  <= StIdle;
         gapCntQ <= '0;
      end else begin
         stateQ  <= stateD;
         gapCntQ <= gapCntD;
      end
   end

   always_comb begin
      stateD  = stateQ;
      gapCntD = gapCntQ;
      unique case (stateQ)
         StIdle: begin
            if (winClr)     stateD = StClrStb;
            else if (winRd) stateD = StRdStb;
            else if (winWr) stateD = StWrStb;
         end
         StWrStb:  stateD = StWrHold;
         StRdStb:  stateD = StRdCap;
         StClrStb: stateD = StRel;
         StWrHold, StRdCap, StRel: begin
            if (NoGap) begin
               stateD = StIdle;
            end else begin
               stateD  = StGap;
               gapCntD = GapLoad;
            end
         end
         StGap: begin
            if (gapCntQ == 4'd0) stateD = StIdle;
            else                 gapCntD = gapCntQ - 4'd1;
         end
         default: stateD = StIdle;
      endcase
   end

   always_comb begin
      strobe = 2'b00;
      unique case (stateQ)
         StWrStb:  strobe = 2'b01;
         StRdStb:  strobe = 2'b10;
         StClrStb: strobe = 2'b11;
         default:  strobe = 2'b00;
      endcase
      tx_ready = winWr;
      busy     = (stateQ != StIdle);
   end

   // A capture in the same cycle as a consume keeps rx_valid high with the new byte.
   always_comb begin
      rxValidD = rxValidQ;
      if (stateQ == StRdCap)        rxValidD = 1'b1;
      else if (rxValidQ && rx_ready) rxValidD = 1'b0;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         txDataQ  <= '0;
         rxByteQ  <= '0;
         rxValidQ <= 1'b0;
         rateQ    <= '0;
         startedQ <= 1'b0;
      end else begin
         rateQ    <= rate_sel;
         startedQ <= 1'b1;
         rxValidQ <= rxValidD;
         if (winWr)              txDataQ <= tx_byte;
         if (stateQ == StRdCap)  rxByteQ <= rx_data;
      end
   end

   assign control  = {strobe, rateQ};
   assign tx_data  = txDataQ;
   assign rx_byte  = rxByteQ;
   assign rx_valid = rxValidQ;

endmodule

// File: tb/tb_uart_host_sequencer.sv
// Bench for uart_host_sequencer: directed scenarios plus random traffic, all checked against
// a transaction-level model that expands each granted request into its expected strobe pattern.
module tb_uart_host_sequencer;

   localparam int unsigned Gap = 1;

   logic       clk = 1'b0;
   logic       nReset;
   logic       tx_valid, rx_req, rx_ready, clear_req;
   logic [7:0] tx_byte, rx_data;
   logic [1:0] rate_sel;
   logic       tx_ready, rx_valid, busy;
   logic [7:0] rx_byte, tx_data;
   logic [3:0] control;

   int total = 0;
   int bad   = 0;

   // Model: queue of per-cycle expected strobe codes for the transaction in flight
   // (value+4 marks the cycle in which rx_data is captured).
   int         mq[$];
   bit         mStarted;
   logic [7:0] mTxData, mRxByte;
   logic       mRxValid;
   logic [1:0] mRate;

   uart_host_sequencer #(.GapCycles(Gap)) dut (
      .clk(clk), .nReset(nReset),
      .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
      .rx_req(rx_req), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
      .clear_req(clear_req), .rate_sel(rate_sel), .control(control),
      .tx_data(tx_data), .rx_data(rx_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mreset();
      mq.delete();
      mStarted = 0;
      mTxData  = 8'h00;
      mRxByte  = 8'h00;
      mRxValid = 1'b0;
      mRate    = 2'b00;
   endtask

   task automatic push_gaps();
      for (int i = 0; i < int'(Gap); i++) mq.push_back(0);
   endtask

   // One clock cycle: drive inputs after the falling edge, check outputs, advance the model.
   task automatic step(input logic tv, input logic [7:0] tb, input logic rq, input logic rr,
                       input logic cr, input logic [1:0] rs, input logic [7:0] rd);
      bit         wasBusy, cap;
      logic [1:0] expStb;
      logic       expRdy;
      @(negedge clk);
      tx_valid = tv; tx_byte = tb; rx_req = rq; rx_ready = rr;
      clear_req = cr; rate_sel = rs; rx_data = rd;
      #1;
      wasBusy = (mq.size() != 0);
      expStb  = 2'b00;
      expRdy  = 1'b0;
      cap     = 0;
      if (wasBusy) begin
         expStb = 2'(mq[0] % 4);
         cap    = (mq[0] >= 4);
      end else if (mStarted) begin
         if (cr) begin
            mq.push_back(3); mq.push_back(0); push_gaps();
         end else if (rq && (!mRxValid || rr)) begin
            mq.push_back(2); mq.push_back(4); push_gaps();
         end else if (tv) begin
            expRdy = 1'b1;
            mq.push_back(1); mq.push_back(0); push_gaps();
         end
      end
      chk("busy", busy, wasBusy);
      chk("tx_ready", tx_ready, expRdy);
      chk("control", control, {expStb, mRate});
      chk("tx_data", tx_data, mTxData);
      chk("rx_valid", rx_valid, mRxValid);
      chk("rx_byte", rx_byte, mRxByte);
      if (wasBusy) void'(mq.pop_front());
      if (expRdy) mTxData = tb;
      if (cap) begin
         mRxValid = 1'b1;
         mRxByte  = rd;
      end else if (mRxValid && rr) begin
         mRxValid = 1'b0;
      end
      mRate    = rs;
      mStarted = 1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, mRate, 8'h00);
   endtask

   initial begin
      int         strobes[$];
      int         zeros, minZeros, rdCnt, wrCnt;
      bit         seen, cr, rq, tv;
      logic [1:0] s;

      mreset();
      nReset = 1'b0;
      tx_valid = 1; tx_byte = 8'h55; rx_req = 1; rx_ready = 1;
      clear_req = 1; rate_sel = 2'b11; rx_data = 8'hFF;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_control", control, 4'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tx_ready", tx_ready, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_rx_byte", rx_byte, 8'h00);
      @(posedge clk);
      #1 nReset = 1'b1;

      // Write 0xA5; first cycle after release must not arbitrate
      step(1, 8'hA5, 0, 0, 0, 2'b00, 8'h00);
      chk("wr_holdoff_ready", tx_ready, 1'b0);
      step(1, 8'hA5, 0, 0, 0, 2'b00, 8'h00);
      chk("wr_ready", tx_ready, 1'b1);
      step(0, 8'h00, 0, 0, 0, 2'b00, 8'h00);
      chk("wr_stb", control[3:2], 2'b01);
      chk("wr_stb_data", tx_data, 8'hA5);
      step(0, 8'h00, 0, 0, 0, 2'b00, 8'h00);
      chk("wr_hold", control[3:2], 2'b00);
      chk("wr_hold_data", tx_data, 8'hA5);
      step(0, 8'h00, 0, 0, 0, 2'b00, 8'h00);
      chk("wr_gap_busy", busy, 1'b1);
      step(0, 8'h00, 0, 0, 0, 2'b00, 8'h00);
      chk("wr_idle", busy, 1'b0);

      // Read returning 0x3C
      step(0, 8'h00, 1, 0, 0, 2'b00, 8'h00);
      step(0, 8'h00, 0, 0, 0, 2'b00, 8'h00);
      chk("rd_stb", control[3:2], 2'b10);
      step(0, 8'h00, 0, 0, 0, 2'b00, 8'h3C);
      step(0, 8'h00, 0, 0, 0, 2'b00, 8'h00);
      chk("rd_valid", rx_valid, 1'b1);
      chk("rd_byte", rx_byte, 8'h3C);
      idle(3);

      // Priority: all requests together, each dropped once its strobe appears
      cr = 1; rq = 1; tv = 1; zeros = 0; minZeros = 99;
      for (int i = 0; i < 24; i++) begin
         step(tv, 8'h96, rq, 1, cr, 2'b01, 8'h77);
         s = control[3:2];
         if (s != 2'b00) begin
            if (strobes.size() != 0 && zeros < minZeros) minZeros = zeros;
            strobes.push_back(int'(s));
            zeros = 0;
            if (s == 2'b11) cr = 0;
            if (s == 2'b10) rq = 0;
            if (s == 2'b01) tv = 0;
         end else begin
            zeros++;
         end
      end
      chk("prio_count", strobes.size(), 3);
      if (strobes.size() == 3) begin
         chk("prio_first", strobes[0], 3);
         chk("prio_second", strobes[1], 2);
         chk("prio_third", strobes[2], 1);
      end
      chk("prio_spacing", minZeros >= 1 + int'(Gap), 1);
      idle(2);

      // Backpressure: rx_valid held, read must wait while writes proceed
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(0, 8'h00, 1, 0, 0, 2'b01, 8'hC3);
         seen = rx_valid;
      end
      chk("bp_prime", seen, 1'b1);
      idle(5);
      rdCnt = 0; wrCnt = 0;
      for (int i = 0; i < 12; i++) begin
         step(1, 8'(i), 1, 0, 0, 2'b01, 8'h11);
         if (control[3:2] == 2'b10) rdCnt++;
         if (control[3:2] == 2'b01) wrCnt++;
      end
      chk("bp_no_read", rdCnt, 0);
      chk("bp_writes", wrCnt > 0, 1);
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(0, 8'h00, 1, 1, 0, 2'b01, 8'h22);
         seen = (control[3:2] == 2'b10);
      end
      chk("bp_read_after_ready", seen, 1'b1);
      idle(5);

      // Rate select: visible one cycle later
      step(0, 8'h00, 0, 0, 0, 2'b00, 8'h00);
      step(0, 8'h00, 0, 0, 0, 2'b11, 8'h00);
      chk("rate_not_yet", control[1:0], 2'b00);
      step(0, 8'h00, 0, 0, 0, 2'b11, 8'h00);
      chk("rate_applied", control, 4'b0011);

      // Reset in the middle of a write strobe
      step(1, 8'h5A, 0, 0, 0, 2'b11, 8'h00);
      step(0, 8'h00, 0, 0, 0, 2'b11, 8'h00);
      chk("mid_rst_stb", control[3:2], 2'b01);
      nReset = 1'b0;
      #1;
      chk("mid_rst_control", control, 4'h0);
      chk("mid_rst_busy", busy, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tx_valid = 1; rx_req = 1; clear_req = 1;
         #1;
         chk("mid_rst_quiet", control, 4'h0);
      end
      mreset();
      @(posedge clk);
      #1 nReset = 1'b1;

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, 2'($urandom),
              8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
